// File: rtl/sysreg_wr_arb0_pkg.sv
// Shared definitions for the system register write-port arbiter.
package sysreg_wr_arb0_pkg;

   localparam int SYSREG_NUM_W = 3;
   localparam int SYSREG_CNT   = 8;
   localparam logic [2:0] SYSREG_MOD_SEL = 3'b101;

   // Which requester owns the write port this cycle
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_INS  = 2'd1,
      GNT_CTRL = 2'd2
   } grant_e;

   // Register number to one-hot write-enable vector (bit n for register n)
   function automatic logic [SYSREG_CNT-1:0] sysreg_onehot(input logic [SYSREG_NUM_W-1:0] num);
      logic [SYSREG_CNT-1:0] vec;
      vec      = '0;
      vec[num] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/sysreg_pkt_fifo0.sv
// Small synchronous FIFO buffering control-packet sysreg writes.
module sysreg_pkt_fifo0 #(
   parameter int DEPTH = 4,
   parameter int W     = 35
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rptr];

   // Pointers wrap naturally; count tracks occupancy and is unchanged on push+pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; entries only become visible through the pointers
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/sysreg_wr_arb0.sv
// Arbitrates control-packet writes and sysreg instructions onto the single
// system register write port and registers the committed write.
module sysreg_wr_arb0
   import sysreg_wr_arb0_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                    clk_i_sa0,
   input  logic                    rst_i_sa0,
   input  logic                    ctrl_req_i_sa0,
   input  logic [SYSREG_NUM_W-1:0] ctrl_num_i_sa0,
   input  logic [DW-1:0]           ctrl_data_i_sa0,
   output logic                    ctrl_full_o_sa0,
   input  logic                    ins_req_i_sa0,
   input  logic [SYSREG_NUM_W-1:0] ins_num_i_sa0,
   input  logic [DW-1:0]           ins_data_i_sa0,
   output logic                    ins_stall_o_sa0,
   output logic [SYSREG_CNT-1:0]   sysreg_wen_vctr_o_sa0,
   output logic [DW-1:0]           sysreg_wdata_o_sa0,
   output logic                    sysreg_w_terminate_o_sa0
);

   localparam int EW = SYSREG_NUM_W + DW;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [EW-1:0]           fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW-1:0]           fifo_count;
   logic [SYSREG_NUM_W-1:0] head_num;
   logic [DW-1:0]           head_data;
   logic                    head_valid;
   logic                    fifo_at_cap;
   logic                    contended;
   logic                    last_ctrl;
   logic                    ctrl_grant;
   logic                    ins_grant;
   grant_e                  grant;

   sysreg_pkt_fifo0 #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk_i_sa0),
      .rst   (rst_i_sa0),
      .push  (ctrl_req_i_sa0),
      .pop   (ctrl_grant),
      .wdata ({ctrl_num_i_sa0, ctrl_data_i_sa0}),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Head validity comes from registered state, so a packet arriving into an
   // empty FIFO is never granted in its arrival cycle
   assign head_num        = fifo_head[EW-1:DW];
   assign head_data       = fifo_head[DW-1:0];
   assign head_valid      = ~fifo_empty;
   assign fifo_at_cap     = (fifo_count == CW'(DEPTH));
   assign contended       = head_valid & ins_req_i_sa0;
   assign ctrl_full_o_sa0 = fifo_full;
   assign ctrl_grant      = (grant == GNT_CTRL);
   assign ins_grant       = (grant == GNT_INS);
   assign ins_stall_o_sa0 = ins_req_i_sa0 & ~ins_grant;

   // Full FIFO always drains first; otherwise alternate under contention
   always_comb begin
      grant = GNT_NONE;
      if (contended) begin
         if (fifo_at_cap || !last_ctrl) grant = GNT_CTRL;
         else                           grant = GNT_INS;
      end else if (head_valid) begin
         grant = GNT_CTRL;
      end else if (ins_req_i_sa0) begin
         grant = GNT_INS;
      end
   end

   // Commit the granted write one cycle later and remember who won a contest
   always_ff @(posedge clk_i_sa0) begin
      if (rst_i_sa0) begin
         sysreg_wen_vctr_o_sa0    <= '0;
         sysreg_wdata_o_sa0       <= '0;
         sysreg_w_terminate_o_sa0 <= 1'b0;
         last_ctrl                <= 1'b1;
      end else begin
         sysreg_w_terminate_o_sa0 <= ctrl_grant;
         sysreg_wen_vctr_o_sa0    <= '0;
         case (grant)
            GNT_CTRL: begin
               sysreg_wen_vctr_o_sa0 <= sysreg_onehot(head_num);
               sysreg_wdata_o_sa0    <= head_data;
            end
            GNT_INS: begin
               sysreg_wen_vctr_o_sa0 <= sysreg_onehot(ins_num_i_sa0);
               sysreg_wdata_o_sa0    <= ins_data_i_sa0;
            end
            default: begin
            end
         endcase
         if (contended) last_ctrl <= ctrl_grant;
      end
   end

endmodule
